// File: rtl/axi_sram_master_pkg.sv
// Shared definitions for the SRAM-like to AXI3 master bridge.
// Contents: AXI3 field widths, fixed burst/response encodings and the
// state types of the read and write FSMs.
package axi_sram_master_pkg;

    localparam int LEN_W   = 4;   // AXI3 burst length field
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;   // AXI3 lock field
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int RESP_W  = 2;

    localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
    localparam logic [RESP_W-1:0]  RESP_OKAY  = 2'b00;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ADDR = 1'b1
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

endpackage

// File: rtl/axi_sram_master_if.sv
// AXI3 bus between the bridge (master modport) and the interconnect
// (slave modport). All five channels follow the usual AXI rule: a beat
// transfers on a rising clock edge where valid and ready are both high;
// valid, once raised, holds its payload stable until that edge, and
// valid never waits on ready.
interface axi_sram_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    import axi_sram_master_pkg::*;

    // read address
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [LEN_W-1:0]    arlen;
    logic [SIZE_W-1:0]   arsize;
    logic [BURST_W-1:0]  arburst;
    logic [LOCK_W-1:0]   arlock;
    logic [CACHE_W-1:0]  arcache;
    logic [PROT_W-1:0]   arprot;
    logic                arvalid;
    logic                arready;
    // read data
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [RESP_W-1:0]   rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    // write address
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [LEN_W-1:0]    awlen;
    logic [SIZE_W-1:0]   awsize;
    logic [BURST_W-1:0]  awburst;
    logic [LOCK_W-1:0]   awlock;
    logic [CACHE_W-1:0]  awcache;
    logic [PROT_W-1:0]   awprot;
    logic                awvalid;
    logic                awready;
    // write data
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    // write response
    logic [ID_W-1:0]     bid;
    logic [RESP_W-1:0]   bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_rd_tracker.sv
// Outstanding-read bookkeeping for the bridge.
// Ports: ar_hs / r_hs are the AR and R handshakes seen this cycle; r_id,
// r_last, r_data, r_resp are the R beat fields. rd_cnt is the number of
// reads issued and not yet returned, rd_full says no more may be issued.
// ret_ok/ret_data/ret_err are the registered return pulse and payload.
module axi_rd_tracker
    import axi_sram_master_pkg::*;
#(
    parameter int  DATA_W     = 32,
    parameter int  ID_W       = 4,
    parameter int  RD_ID      = 0,
    parameter int  MAX_RD_OUT = 4,
    localparam int CNT_W      = $clog2(MAX_RD_OUT + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ar_hs,
    input  logic              r_hs,
    input  logic [ID_W-1:0]   r_id,
    input  logic              r_last,
    input  logic [DATA_W-1:0] r_data,
    input  logic [RESP_W-1:0] r_resp,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic              rd_full,
    output logic              ret_ok,
    output logic [DATA_W-1:0] ret_data,
    output logic              ret_err
);

    // Beats carrying a foreign ID are accepted (rready is always high) but
    // neither counted nor reported.
    logic ret_hs;
    assign ret_hs  = r_hs && r_last && (r_id == ID_W'(RD_ID));
    assign rd_full = (rd_cnt == CNT_W'(MAX_RD_OUT));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt   <= '0;
            ret_ok   <= 1'b0;
            ret_err  <= 1'b0;
            ret_data <= '0;
        end else begin
            ret_ok  <= ret_hs;
            ret_err <= ret_hs && (r_resp != RESP_OKAY);
            if (ret_hs) begin
                ret_data <= r_data;
            end
            // issue and return in the same cycle cancel out
            case ({ar_hs, ret_hs})
                2'b10:   rd_cnt <= rd_cnt + CNT_W'(1);
                2'b01:   rd_cnt <= rd_cnt - CNT_W'(1);
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end

endmodule

// File: rtl/axi_sram_master.sv
// SRAM-like request port to AXI3 master bridge, single-beat transfers.
// Ports: clk, resetn (async, active low); request side req/wr/size/addr/
// wdata/wstrb with addr_ok (accepted) and data_ok/rdata/resp_err (done)
// pulses; axi is the AXI3 master; dbg_* expose FSM states and rd_cnt.
// Reads may be pipelined up to MAX_RD_OUT deep; a write only starts with
// no read outstanding and blocks reads until its B response, which keeps
// RAW/WAR ordering without comparing addresses.
module axi_sram_master
    import axi_sram_master_pkg::*;
#(
    parameter int  DATA_W     = 32,
    parameter int  ADDR_W     = 32,
    parameter int  ID_W       = 4,
    parameter int  RD_ID      = 0,
    parameter int  WR_ID      = 1,
    parameter int  MAX_RD_OUT = 4,
    localparam int CNT_W      = $clog2(MAX_RD_OUT + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req,
    input  logic                wr,
    input  logic [SIZE_W-1:0]   size,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                addr_ok,
    output logic                data_ok,
    output logic [DATA_W-1:0]   rdata,
    output logic                resp_err,
    axi_sram_master_if.master   axi,
    output r_state_t            dbg_r_state,
    output w_state_t            dbg_w_state,
    output logic [CNT_W-1:0]    dbg_rd_cnt
);

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic                ready_q;
    logic                arvalid_q, awvalid_q, wvalid_q;
    logic [ADDR_W-1:0]   araddr_q, awaddr_q;
    logic [SIZE_W-1:0]   arsize_q, awsize_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                wr_ok_q, wr_err_q;

    logic [CNT_W-1:0]    rd_cnt;
    logic                rd_full, rd_ok, rd_err;
    logic [DATA_W-1:0]   rd_data;
    logic                ar_hs, r_start, w_start, aw_ok, w_ok;

    assign ar_hs = arvalid_q && axi.arready;
    // a channel is finished once its valid has dropped or it completes now
    assign aw_ok = !awvalid_q || axi.awready;
    assign w_ok  = !wvalid_q  || axi.wready;

    axi_rd_tracker #(
        .DATA_W     (DATA_W),
        .ID_W       (ID_W),
        .RD_ID      (RD_ID),
        .MAX_RD_OUT (MAX_RD_OUT)
    ) u_rd_tracker (
        .clk      (clk),
        .resetn   (resetn),
        .ar_hs    (ar_hs),
        .r_hs     (axi.rvalid && ready_q),
        .r_id     (axi.rid),
        .r_last   (axi.rlast),
        .r_data   (axi.rdata),
        .r_resp   (axi.rresp),
        .rd_cnt   (rd_cnt),
        .rd_full  (rd_full),
        .ret_ok   (rd_ok),
        .ret_data (rd_data),
        .ret_err  (rd_err)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    always_comb begin
        r_next  = r_state;
        w_next  = w_state;
        r_start = 1'b0;
        w_start = 1'b0;
        addr_ok = 1'b0;

        case (r_state)
            R_IDLE: begin
                if (req && !wr && !rd_full && w_state == W_IDLE) begin
                    r_next  = R_ADDR;
                    r_start = 1'b1;
                end
            end
            R_ADDR: begin
                if (axi.arready) begin
                    r_next  = R_IDLE;
                    addr_ok = 1'b1;
                end
            end
            default: r_next = R_IDLE;
        endcase

        case (w_state)
            W_IDLE: begin
                if (req && wr && rd_cnt == '0 && r_state == R_IDLE) begin
                    w_next  = W_ADDR;
                    w_start = 1'b1;
                end
            end
            W_ADDR: begin
                if (aw_ok && w_ok) begin
                    w_next  = W_RESP;
                    addr_ok = 1'b1;
                end
            end
            W_RESP: begin
                if (axi.bvalid) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q   <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            araddr_q  <= '0;
            arsize_q  <= '0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_ok_q   <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;

            if (r_start) begin
                araddr_q  <= addr;
                arsize_q  <= size;
                arvalid_q <= 1'b1;
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
            end

            if (w_start) begin
                awaddr_q  <= addr;
                awsize_q  <= size;
                wdata_q   <= wdata;
                wstrb_q   <= wstrb;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
            end else begin
                if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
                if (wvalid_q && axi.wready)   wvalid_q  <= 1'b0;
            end

            wr_ok_q  <= (w_state == W_RESP) && axi.bvalid;
            wr_err_q <= (w_state == W_RESP) && axi.bvalid && (axi.bresp != RESP_OKAY);
        end
    end

    // Reads and writes never overlap, so their done pulses can simply be ORed.
    assign data_ok  = rd_ok || wr_ok_q;
    assign resp_err = rd_err || wr_err_q;
    assign rdata    = rd_data;

    assign axi.arid    = ID_W'(RD_ID);
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = '0;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = ready_q;

    assign axi.awid    = ID_W'(WR_ID);
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = '0;
    assign axi.awsize  = awsize_q;
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = '0;
    assign axi.awcache = '0;
    assign axi.awprot  = '0;
    assign axi.awvalid = awvalid_q;
    assign axi.wid     = ID_W'(WR_ID);
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = ready_q;

    assign dbg_r_state = r_state;
    assign dbg_w_state = w_state;
    assign dbg_rd_cnt  = rd_cnt;

    // writes are serialised, so the B channel ID carries no information
    logic unused_bid;
    assign unused_bid = ^axi.bid;

endmodule

// File: tb/tb_axi_sram_master.sv
// Directed bench for axi_sram_master: the bench plays the AXI slave and the
// CPU request side, with hand-computed expected values.
module tb_axi_sram_master;
    import axi_sram_master_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int MAXRD  = 4;
    localparam int CNT_W  = $clog2(MAXRD + 1);

    logic              clk;
    logic              resetn;
    logic              req, wr;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              addr_ok, data_ok, resp_err;
    logic [DATA_W-1:0] rdata;
    r_state_t          dbg_r_state;
    w_state_t          dbg_w_state;
    logic [CNT_W-1:0]  dbg_rd_cnt;

    int err_cnt = 0;
    int chk_cnt = 0;
    int ar_hs_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    axi_sram_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) axi ();

    axi_sram_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W),
        .RD_ID(0), .WR_ID(1), .MAX_RD_OUT(MAXRD)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .resp_err(resp_err),
        .axi(axi.master),
        .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state), .dbg_rd_cnt(dbg_rd_cnt)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", err_cnt, chk_cnt);
        $fatal(1);
    end

    always @(negedge clk) if (axi.arvalid && axi.arready) ar_hs_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // move to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // hold a read request until addr_ok (arready assumed high), then drop it
    task automatic issue_read(input logic [31:0] a, input string tag);
        logic got;
        req = 1'b1; wr = 1'b0; addr = a; size = 3'd2;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            step(); #1;
            if (addr_ok) got = 1'b1;
        end
        check(tag, got, 1'b1);
        step();
        req = 1'b0;
    endtask

    // one R beat in the current cycle
    task automatic r_return(input logic [31:0] d, input logic [3:0] id, input logic [1:0] resp);
        axi.rvalid = 1'b1; axi.rdata = d; axi.rlast = 1'b1; axi.rid = id; axi.rresp = resp;
        step();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
    endtask

    task automatic check_return(input string tag, input logic err);
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        check({tag, "_data_ok"}, data_ok, 1'b1);
        check({tag, "_rdata"}, rdata, e);
        check({tag, "_resp_err"}, resp_err, err);
    endtask

    initial begin
        logic got;
        int hs0;
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = '0; addr = '0; wdata = '0; wstrb = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0;
        axi.rlast = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.bid = '0; axi.bresp = '0;

        // ---------------- reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_arvalid", axi.arvalid, 1'b0);
        check("rst_awvalid", axi.awvalid, 1'b0);
        check("rst_wvalid", axi.wvalid, 1'b0);
        check("rst_rready", axi.rready, 1'b0);
        check("rst_bready", axi.bready, 1'b0);
        check("rst_addr_ok", addr_ok, 1'b0);
        check("rst_data_ok", data_ok, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_araddr", axi.araddr, 32'h0);
        check("rst_wdata", axi.wdata, 32'h0);
        check("rst_rd_cnt", dbg_rd_cnt, 3'd0);
        step();
        resetn = 1'b1;
        step(); #1;
        check("rel_rready", axi.rready, 1'b1);
        check("rel_bready", axi.bready, 1'b1);

        // ---------------- single read, arready and rvalid one cycle late
        req = 1'b1; wr = 1'b0; addr = 32'h100; size = 3'd2; #1;
        check("t1_arvalid_c0", axi.arvalid, 1'b0);
        step(); #1;
        check("t1_arvalid_c1", axi.arvalid, 1'b1);
        check("t1_araddr", axi.araddr, 32'h100);
        check("t1_arsize", axi.arsize, 3'd2);
        check("t1_arlen", axi.arlen, 4'd0);
        check("t1_arburst", axi.arburst, 2'b01);
        check("t1_arid", axi.arid, 4'd0);
        check("t1_addr_ok_c1", addr_ok, 1'b0);
        step(); axi.arready = 1'b1; #1;
        check("t1_addr_ok_c2", addr_ok, 1'b1);
        step(); req = 1'b0; axi.arready = 1'b0; #1;
        check("t1_arvalid_c3", axi.arvalid, 1'b0);
        check("t1_addr_ok_c3", addr_ok, 1'b0);
        check("t1_rd_cnt_c3", dbg_rd_cnt, 3'd1);
        step(); axi.rvalid = 1'b1; axi.rdata = 32'hDEADBEEF; axi.rlast = 1'b1;
        axi.rid = '0; axi.rresp = 2'b00; #1;
        check("t1_data_ok_c4", data_ok, 1'b0);
        step(); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
        exp_q.push_back(32'hDEADBEEF);
        check_return("t1", 1'b0);
        check("t1_rd_cnt_c5", dbg_rd_cnt, 3'd0);
        step(); #1;
        check("t1_data_ok_c6", data_ok, 1'b0);

        // ---------------- five reads, MAX_RD_OUT = 4, no returns
        axi.arready = 1'b1;
        hs0 = ar_hs_cnt;
        for (int i = 0; i < 4; i++) issue_read(32'h1000 + 32'(i * 4), "t2_addr_ok");
        req = 1'b1; addr = 32'h1010; #1;
        check("t2_rd_cnt_full", dbg_rd_cnt, 3'd4);
        check("t2_ar_hs_4", ar_hs_cnt - hs0, 4);
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(); #1;
            if (addr_ok || axi.arvalid) got = 1'b1;
        end
        check("t2_stall", got, 1'b0);
        step(); axi.rvalid = 1'b1; axi.rdata = 32'hA000_0000; axi.rlast = 1'b1; axi.rid = '0; #1;
        check("t2_arvalid_ret_cycle", axi.arvalid, 1'b0);
        step(); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
        exp_q.push_back(32'hA000_0000);
        check_return("t2_ret0", 1'b0);
        check("t2_rd_cnt_3", dbg_rd_cnt, 3'd3);
        check("t2_arvalid_after_ret", axi.arvalid, 1'b0);
        step(); #1;
        check("t2_arvalid_5th", axi.arvalid, 1'b1);
        check("t2_araddr_5th", axi.araddr, 32'h1010);
        check("t2_addr_ok_5th", addr_ok, 1'b1);
        step(); req = 1'b0; #1;
        check("t2_rd_cnt_back_4", dbg_rd_cnt, 3'd4);
        check("t2_ar_hs_5", ar_hs_cnt - hs0, 5);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'hA000_0001 + 32'(i));
            r_return(32'hA000_0001 + 32'(i), 4'd0, 2'b00);
            #1;
            check_return("t2_drain", 1'b0);
        end
        check("t2_rd_cnt_0", dbg_rd_cnt, 3'd0);

        // ---------------- AR handshake and R return in the same cycle
        issue_read(32'h2000, "t3_addr_ok0");
        issue_read(32'h2004, "t3_addr_ok1");
        req = 1'b1; addr = 32'h2008; #1;
        check("t3_rd_cnt_2", dbg_rd_cnt, 3'd2);
        step();
        axi.rvalid = 1'b1; axi.rdata = 32'hB0; axi.rlast = 1'b1; axi.rid = '0; #1;
        check("t3_addr_ok_same", addr_ok, 1'b1);
        step(); axi.rvalid = 1'b0; axi.rlast = 1'b0; req = 1'b0; #1;
        exp_q.push_back(32'hB0);
        check_return("t3_ret", 1'b0);
        check("t3_rd_cnt_same", dbg_rd_cnt, 3'd2);
        // foreign-ID beat is swallowed
        r_return(32'hEEEE, 4'd3, 2'b00); #1;
        check("t3_foreign_data_ok", data_ok, 1'b0);
        check("t3_foreign_rd_cnt", dbg_rd_cnt, 3'd2);
        exp_q.push_back(32'hB1);
        r_return(32'hB1, 4'd0, 2'b10); #1;
        check_return("t3_err_ret", 1'b1);
        exp_q.push_back(32'hB2);
        r_return(32'hB2, 4'd0, 2'b00); #1;
        check_return("t3_last_ret", 1'b0);
        check("t3_rd_cnt_0", dbg_rd_cnt, 3'd0);

        // ---------------- write, wready 3 cycles after awready, SLVERR
        axi.arready = 1'b0;
        step();
        req = 1'b1; wr = 1'b1; addr = 32'h200; size = 3'd2; wdata = 32'h12345678; wstrb = 4'hF;
        step(); #1;
        check("t4_awvalid", axi.awvalid, 1'b1);
        check("t4_wvalid", axi.wvalid, 1'b1);
        check("t4_awaddr", axi.awaddr, 32'h200);
        check("t4_awsize", axi.awsize, 3'd2);
        check("t4_awlen", axi.awlen, 4'd0);
        check("t4_awid", axi.awid, 4'd1);
        check("t4_wid", axi.wid, 4'd1);
        check("t4_wdata", axi.wdata, 32'h12345678);
        check("t4_wstrb", axi.wstrb, 4'hF);
        check("t4_wlast", axi.wlast, 1'b1);
        check("t4_addr_ok_c1", addr_ok, 1'b0);
        step(); axi.awready = 1'b1; #1;
        check("t4_addr_ok_aw_only", addr_ok, 1'b0);
        step(); axi.awready = 1'b0; #1;
        check("t4_awvalid_dropped", axi.awvalid, 1'b0);
        check("t4_wvalid_held", axi.wvalid, 1'b1);
        check("t4_addr_ok_c3", addr_ok, 1'b0);
        step();
        step(); axi.wready = 1'b1; #1;
        check("t4_addr_ok_both", addr_ok, 1'b1);
        step(); axi.wready = 1'b0; req = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b10; #1;
        check("t4_wvalid_dropped", axi.wvalid, 1'b0);
        check("t4_w_resp", 64'(dbg_w_state), 64'(W_RESP));
        check("t4_data_ok_b_cycle", data_ok, 1'b0);
        step(); axi.bvalid = 1'b0; #1;
        check("t4_data_ok", data_ok, 1'b1);
        check("t4_resp_err", resp_err, 1'b1);
        check("t4_w_idle", 64'(dbg_w_state), 64'(W_IDLE));
        step(); #1;
        check("t4_data_ok_once", data_ok, 1'b0);

        // ---------------- hazards: write waits for reads, read waits for B
        axi.arready = 1'b1;
        issue_read(32'h300, "t5_rd_addr_ok");
        req = 1'b1; wr = 1'b1; addr = 32'h304; wdata = 32'h55AA55AA; wstrb = 4'h3;
        axi.awready = 1'b1; axi.wready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            if (axi.awvalid) got = 1'b1;
        end
        check("t5_aw_blocked", got, 1'b0);
        exp_q.push_back(32'hC0);
        r_return(32'hC0, 4'd0, 2'b00); #1;
        check_return("t5_rd_ret", 1'b0);
        check("t5_awvalid_same", axi.awvalid, 1'b0);
        step(); #1;
        check("t5_awvalid", axi.awvalid, 1'b1);
        check("t5_wstrb", axi.wstrb, 4'h3);
        check("t5_wr_addr_ok", addr_ok, 1'b1);
        step(); req = 1'b1; wr = 1'b0; addr = 32'h308; #1;
        got = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            if (axi.arvalid) got = 1'b1;
        end
        check("t5_ar_blocked", got, 1'b0);
        axi.bvalid = 1'b1; axi.bresp = 2'b00;
        step(); axi.bvalid = 1'b0; #1;
        check("t5_wr_data_ok", data_ok, 1'b1);
        check("t5_wr_resp_err", resp_err, 1'b0);
        check("t5_arvalid_same", axi.arvalid, 1'b0);
        step(); #1;
        check("t5_arvalid", axi.arvalid, 1'b1);
        check("t5_rd2_addr_ok", addr_ok, 1'b1);
        step(); req = 1'b0;
        exp_q.push_back(32'hC1);
        r_return(32'hC1, 4'd0, 2'b00); #1;
        check_return("t5_rd2_ret", 1'b0);

        // ---------------- reset while in W_ADDR
        axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        step();
        req = 1'b1; wr = 1'b1; addr = 32'h400; wdata = 32'h0BADF00D; wstrb = 4'hF;
        step(); #1;
        check("t6_awvalid_pre", axi.awvalid, 1'b1);
        resetn = 1'b0; #1;
        check("t6_awvalid_rst", axi.awvalid, 1'b0);
        check("t6_wvalid_rst", axi.wvalid, 1'b0);
        check("t6_w_idle", 64'(dbg_w_state), 64'(W_IDLE));
        check("t6_r_idle", 64'(dbg_r_state), 64'(R_IDLE));
        check("t6_rready_rst", axi.rready, 1'b0);
        req = 1'b0;
        step(); step();
        resetn = 1'b1;
        step();
        axi.arready = 1'b1;
        issue_read(32'h500, "t6_rd_addr_ok");
        exp_q.push_back(32'hCAFEF00D);
        r_return(32'hCAFEF00D, 4'd0, 2'b00); #1;
        check_return("t6_rd_ret", 1'b0);
        check("t6_rd_cnt_0", dbg_rd_cnt, 3'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
